fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the JOF32 pipeline and the producer side of the decode interface. It owns the program counter and drives the synchronous instruction memory. It holds the IF/ID register that supplies `instruction` to decode, and it consumes the decode stage's branch/jump resolution (`pc_address`, taken flag) to redirect fetch. It also implements stall hold, wrong-path flush, a HALT stop state and a delivered-instruction counter.

## Interface
Parameters:
- `RESET_PC`, default 10'd0: word address fetched first after reset.
- `NOP_WORD`, default 32'h0000_0000: bubble value loaded into IF/ID on flush or halt.
- `HALT_OP`, default 5'b11111: opcode (`instruction[31:27]`) that stops fetch.

Ports (one clock, `clk`; reset `rst` is synchronous and active-high):
- `clk`  in  1  pipeline clock, all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  hazard stall from control; holds PC and IF/ID.
- `redirect`  in  1  decode resolved a taken branch or jump this cycle.
- `pc_address`  in  10  absolute word target from decode (`instruction[9:0]`).
- `imem_addr`  out  10  instruction memory address; combinational, equals next-PC.
- `imem_data`  in  32  memory read data; equals mem[address sampled at the previous edge].
- `instruction`  out  32  IF/ID instruction to decode.
- `pc_out`  out  10  word address of `instruction`.
- `valid`  out  1  `instruction` is a real fetched instruction (0 = bubble).
- `halted`  out  1  fetch is in the HALT state.
- `fetch_count`  out  32  number of instructions delivered to IF/ID since reset.

## Operation
- Registers: `pc_q` (10 b), IF/ID {`instruction`, `pc_out`, `valid`}, `state` ∈ {RUN, HALT}, `fetch_count`.
- `imem_addr` = next-PC, so after each edge `imem_data` = mem[`pc_q`].
- Per-edge priority: `rst` > `stall` > `redirect` > `state`.
- `rst`: `pc_q`←`RESET_PC`; `imem_addr`=`RESET_PC` during reset; `instruction`←`NOP_WORD`; `pc_out`←0; `valid`←0; `state`←RUN; `fetch_count`←0. `halted`=0.
- `stall`=1: next-PC=`pc_q`; IF/ID, `state` and `fetch_count` are held. `redirect` is ignored; decode re-asserts it after the stall clears.
- `redirect`=1 (no stall): next-PC=`pc_address`; IF/ID←{`NOP_WORD`, 0, 0} to flush the wrong-path word; `state`←RUN. Redirect also exits HALT.
- RUN, no stall or redirect: IF/ID←{`imem_data`, `pc_q`, 1}; `fetch_count`+1.
  - If `imem_data[31:27]`==`HALT_OP`: `state`←HALT and next-PC=`pc_q` (the HALT word is still delivered).
  - Otherwise next-PC=`pc_q`+1, mod 1024.
- HALT, no stall or redirect: next-PC=`pc_q`; IF/ID←{`NOP_WORD`, 0, 0}; counter held.
- PC arithmetic is 10-bit unsigned. 10'h3FF+1 wraps to 10'h000 without a flag.
- `fetch_count` wraps 32'hFFFF_FFFF→0.

## Timing
- Reset must be held at least one edge. The first edge after release loads mem[`RESET_PC`] into IF/ID with `valid`=1.
- Throughput: one instruction per cycle in RUN without stall.
- Redirect penalty: 1 bubble.
  - `redirect` sampled at edge t gives IF/ID=NOP after t.
  - mem[`pc_address`] is in IF/ID after t+1.
- Stall of N cycles freezes `instruction`/`pc_out`/`valid` for N edges; `imem_addr` stays constant.
- HALT fetched at edge t: `halted`=1 after t; `valid`=0 from edge t+1 onward.
- `rst` asserted mid-stream overrides stall and redirect on that edge. All outputs take reset values after that edge.

## Test plan
- Sequential fetch: mem[i]=32'h0800_0000+i, `RESET_PC`=0; release rst → edges 1..4 give `pc_out` 0,1,2,3 and `instruction` mem[0..3], `valid`=1, `fetch_count`=4.
- Stall: assert `stall` for 2 cycles while `pc_out`=2 → `instruction`=mem[2] held 2 extra cycles, `imem_addr` constant, `fetch_count` unchanged; then resumes with pc 3.
- Redirect: `redirect`=1, `pc_address`=10'h040 at pc 5 → next cycle `valid`=0 with `NOP_WORD`, following cycle `pc_out`=10'h040 with mem[0x40]. Same request with `stall`=1 → ignored, sequential fetch continues after the stall.
- HALT: mem[3]=32'hF800_0000 → `pc_out` 3 delivered `valid`=1, then `halted`=1, `valid`=0 indefinitely, `fetch_count`=4. Then `redirect` to 10'h010 → `halted`=0 and mem[0x10] follows after one bubble.
- Wrap: `RESET_PC`=10'h3FE → `pc_out` 3FE, 3FF, 000, 001.
- Reset mid-run with `stall`=1 and `redirect`=1 → after the edge: `valid`=0, `pc_out`=0, `fetch_count`=0, `halted`=0. Next edge delivers mem[`RESET_PC`].

Source files
------------

// File: rtl/fetch_unit.sv
// JOF32 instruction fetch stage: owns the PC, drives the synchronous instruction
// memory and holds the IF/ID register, with stall, redirect flush and HALT.
module fetch_unit #(
  parameter logic [9:0]  RESET_PC = 10'd0,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000,
  parameter logic [4:0]  HALT_OP  = 5'b11111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [9:0]  pc_address,
  output logic [9:0]  imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] instruction,
  output logic [9:0]  pc_out,
  output logic        valid,
  output logic        halted,
  output logic [31:0] fetch_count
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [9:0]  pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [9:0]  pc_out_q, pc_out_d;
  logic        valid_q, valid_d;
  logic [0:0]  state_q, state_d;
  logic [31:0] count_q, count_d;
  logic        is_halt_op;

  assign is_halt_op = (imem_data[31:27] == HALT_OP);

  // Next-state selection; priority is reset, stall, redirect, then FSM state.
  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    state_d  = state_q;
    count_d  = count_q;
    if (rst) begin
      pc_d     = RESET_PC;
      instr_d  = NOP_WORD;
      pc_out_d = 10'd0;
      valid_d  = 1'b0;
      state_d  = ST_RUN;
      count_d  = 32'd0;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (redirect) begin
      pc_d     = pc_address;
      instr_d  = NOP_WORD;
      pc_out_d = 10'd0;
      valid_d  = 1'b0;
      state_d  = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          instr_d  = imem_data;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          count_d  = count_q + 32'd1;
          if (is_halt_op) begin
            state_d = ST_HALT;
            pc_d    = pc_q;
          end else begin
            state_d = ST_RUN;
            pc_d    = pc_q + 10'd1;
          end
        end
        ST_HALT: begin
          pc_d     = pc_q;
          instr_d  = NOP_WORD;
          pc_out_d = 10'd0;
          valid_d  = 1'b0;
        end
        default: begin
          state_d = ST_RUN;
          pc_d    = pc_q;
        end
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      instr_q  <= NOP_WORD;
      pc_out_q <= 10'd0;
      valid_q  <= 1'b0;
      state_q  <= ST_RUN;
      count_q  <= 32'd0;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
      state_q  <= state_d;
      count_q  <= count_d;
    end
  end

  // Memory address is the next PC so read data lines up with pc_q after each edge.
  assign imem_addr   = pc_d;
  assign instruction = instr_q;
  assign pc_out      = pc_out_q;
  assign valid       = valid_q;
  assign halted      = (state_q == ST_HALT);
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed test-plan steps plus random stimulus,
// checked against a cycle-level reference model of the fetch rules.
module tb_fetch_unit;

  localparam logic [9:0]  R_PC = 10'd0;
  localparam logic [31:0] NOP  = 32'h1357_9BDF;

  logic        clk = 1'b0;
  logic        rst, stall, redirect;
  logic [9:0]  pc_address;
  logic [9:0]  imem_addr;
  logic [31:0] imem_data;
  logic [31:0] instruction;
  logic [9:0]  pc_out;
  logic        valid, halted;
  logic [31:0] fetch_count;

  logic        rst2;
  logic [9:0]  imem_addr2;
  logic [31:0] imem_data2;
  logic [31:0] instruction2;
  logic [9:0]  pc_out2;
  logic        valid2, halted2;
  logic [31:0] fetch_count2;

  logic [31:0] mem [0:1023];

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  // reference model state
  logic [9:0]  m_fetch;
  logic [31:0] m_instr;
  logic [9:0]  m_pc;
  logic        m_valid, m_halt;
  logic [31:0] m_count;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    imem_data  <= mem[imem_addr];
    imem_data2 <= mem[imem_addr2];
  end

  fetch_unit #(.RESET_PC(R_PC), .NOP_WORD(NOP), .HALT_OP(5'b11111)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .pc_address(pc_address),
    .imem_addr(imem_addr), .imem_data(imem_data), .instruction(instruction),
    .pc_out(pc_out), .valid(valid), .halted(halted), .fetch_count(fetch_count));

  fetch_unit #(.RESET_PC(10'h3FE)) dut_wrap (
    .clk(clk), .rst(rst2), .stall(1'b0), .redirect(1'b0), .pc_address(10'd0),
    .imem_addr(imem_addr2), .imem_data(imem_data2), .instruction(instruction2),
    .pc_out(pc_out2), .valid(valid2), .halted(halted2), .fetch_count(fetch_count2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] next_fetch(input logic r, input logic s, input logic d,
                                            input logic [9:0] a);
    logic [31:0] w;
    w = mem[m_fetch];
    if (r) return R_PC;
    else if (s) return m_fetch;
    else if (d) return a;
    else if (m_halt) return m_fetch;
    else if (w[31:27] == 5'b11111) return m_fetch;
    else return m_fetch + 10'd1;
  endfunction

  task automatic step(input logic r, input logic s, input logic d, input logic [9:0] a);
    logic [9:0]  nf;
    logic [31:0] w;
    @(negedge clk);
    rst = r; stall = s; redirect = d; pc_address = a;
    #1;
    nf = next_fetch(r, s, d, a);
    w  = mem[m_fetch];
    chk("imem_addr", {22'd0, imem_addr}, {22'd0, nf});
    @(posedge clk);
    if (r) begin
      m_instr = NOP; m_pc = 10'd0; m_valid = 1'b0; m_halt = 1'b0; m_count = 32'd0;
    end else if (s) begin
      m_count = m_count;
    end else if (d || m_halt) begin
      m_instr = NOP; m_pc = 10'd0; m_valid = 1'b0;
      if (d) m_halt = 1'b0;
    end else begin
      m_instr = w; m_pc = m_fetch; m_valid = 1'b1; m_count = m_count + 32'd1;
      if (w[31:27] == 5'b11111) m_halt = 1'b1;
    end
    m_fetch = nf;
    #1;
    chk("instruction", instruction, m_instr);
    chk("pc_out", {22'd0, pc_out}, {22'd0, m_pc});
    chk("valid", {31'd0, valid}, {31'd0, m_valid});
    chk("halted", {31'd0, halted}, {31'd0, m_halt});
    chk("fetch_count", fetch_count, m_count);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 10'd0);
  endtask

  initial begin
    logic [9:0]  wpc [4];
    logic [31:0] w;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; pc_address = 10'd0; rst2 = 1'b1;
    m_fetch = R_PC; m_instr = NOP; m_pc = 10'd0; m_valid = 1'b0; m_halt = 1'b0;
    m_count = 32'd0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0800_0000 + i;

    // reset, sequential fetch, 2-cycle stall at pc 2
    step(1'b1, 1'b0, 1'b0, 10'd0);
    step(1'b1, 1'b0, 1'b0, 10'd0);
    run(3);
    step(1'b0, 1'b1, 1'b0, 10'd0);
    step(1'b0, 1'b1, 1'b0, 10'd0);
    run(3);
    // redirect at pc 5, then redirect masked by stall
    step(1'b0, 1'b0, 1'b1, 10'h040);
    run(2);
    step(1'b0, 1'b1, 1'b1, 10'h200);
    run(2);

    // HALT at address 3, then redirect out of HALT
    @(negedge clk);
    mem[3] = 32'hF800_0000;
    step(1'b1, 1'b0, 1'b0, 10'd0);
    run(8);
    step(1'b0, 1'b1, 1'b1, 10'h010);
    run(1);
    step(1'b0, 1'b0, 1'b1, 10'h010);
    run(3);
    // reset overriding stall and redirect
    step(1'b1, 1'b1, 1'b1, 10'h123);
    run(2);

    // random stimulus
    @(negedge clk);
    for (int i = 0; i < 1024; i++) begin
      w = $urandom;
      if ($urandom_range(15, 0) == 0) w[31:27] = 5'b11111;
      else if (w[31:27] == 5'b11111) w[31:27] = 5'b00000;
      mem[i] = w;
    end
    step(1'b1, 1'b0, 1'b0, 10'd0);
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(39, 0) == 0), ($urandom_range(3, 0) == 0),
           ($urandom_range(7, 0) == 0), 10'($urandom));
    end

    // PC wrap from 3FE on a second instance
    @(negedge clk);
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0800_0000 + i;
    @(negedge clk);
    @(negedge clk);
    rst2 = 1'b0;
    wpc[0] = 10'h3FE; wpc[1] = 10'h3FF; wpc[2] = 10'h000; wpc[3] = 10'h001;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("wrap_pc", {22'd0, pc_out2}, {22'd0, wpc[i]});
      chk("wrap_instr", instruction2, 32'h0800_0000 + {22'd0, wpc[i]});
      chk("wrap_valid", {31'd0, valid2}, 32'd1);
      chk("wrap_count", fetch_count2, 32'(i + 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
